// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract/compare unit with N/Z/C/V flags.
// The carry chain is cut into STAGES slices with a valid/ready handshake.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int SW = WIDTH / STAGES;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SLT  = 2'b10;
    localparam logic [1:0] OP_SLTU = 2'b11;

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] pv;
    logic              inv;
    logic [WIDTH-1:0]  b_in;

    assign inv  = op != OP_ADD;
    assign b_in = input2 ^ {WIDTH{inv}};

    // A stage moves when any stage at or after it has room.
    always_comb begin
        logic go;
        go = out_ready;
        adv = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            go = go || !vld[i];
            adv[i] = go;
        end
    end

    always_comb begin
        pv = '0;
        pv[0] = in_valid;
        for (int i = 1; i < STAGES; i++) begin
            pv[i] = vld[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (adv[i]) begin
                    vld[i] <= pv[i];
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld[STAGES-1];

    for (genvar g = 0; g < STAGES; g++) begin : st
        localparam int LO = g * SW;
        localparam int HI = LO + SW;

        logic [SW-1:0] a_sl;
        logic [SW-1:0] b_sl;
        logic          c_in;
        logic [1:0]    op_c;
        logic [SW:0]   sum;

        if (g == 0) begin : src
            assign a_sl = input1[SW-1:0];
            assign b_sl = b_in[SW-1:0];
            assign c_in = inv;
            assign op_c = op;
        end else begin : src
            assign a_sl = st[g-1].rg.a_q[SW-1:0];
            assign b_sl = st[g-1].rg.b_q[SW-1:0];
            assign c_in = st[g-1].rg.c_q;
            assign op_c = st[g-1].rg.op_q;
        end

        assign sum = {1'b0, a_sl} + {1'b0, b_sl} + {{SW{1'b0}}, c_in};

        if (g < STAGES - 1) begin : rg
            // Unconsumed operand bits ride above, finished sum bits below.
            logic [WIDTH-HI-1:0] a_q;
            logic [WIDTH-HI-1:0] b_q;
            logic [WIDTH-HI-1:0] a_nx;
            logic [WIDTH-HI-1:0] b_nx;
            logic [HI-1:0]       s_q;
            logic [HI-1:0]       s_nx;
            logic                c_q;
            logic [1:0]          op_q;

            if (g == 0) begin : nx
                assign a_nx = input1[WIDTH-1:SW];
                assign b_nx = b_in[WIDTH-1:SW];
                assign s_nx = sum[SW-1:0];
            end else begin : nx
                assign a_nx = st[g-1].rg.a_q[WIDTH-LO-1:SW];
                assign b_nx = st[g-1].rg.b_q[WIDTH-LO-1:SW];
                assign s_nx = {sum[SW-1:0], st[g-1].rg.s_q};
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q  <= '0;
                    b_q  <= '0;
                    s_q  <= '0;
                    c_q  <= 1'b0;
                    op_q <= OP_ADD;
                end else if (adv[g] && pv[g]) begin
                    a_q  <= a_nx;
                    b_q  <= b_nx;
                    s_q  <= s_nx;
                    c_q  <= sum[SW];
                    op_q <= op_c;
                end
            end
        end else begin : fin
            logic [WIDTH-1:0] s_full;
            logic [WIDTH-1:0] res;
            logic             n_nx;
            logic             z_nx;
            logic             c_nx;
            logic             v_nx;

            if (g == 0) begin : cat
                assign s_full = sum[SW-1:0];
            end else begin : cat
                assign s_full = {sum[SW-1:0], st[g-1].rg.s_q};
            end

            assign n_nx = s_full[WIDTH-1];
            assign z_nx = s_full == '0;
            assign c_nx = sum[SW];
            assign v_nx = (a_sl[SW-1] == b_sl[SW-1]) && (n_nx != a_sl[SW-1]);

            always_comb begin
                res = '0;
                unique case (op_c)
                    OP_SLT:  res[0] = n_nx ^ v_nx;
                    OP_SLTU: res[0] = ~c_nx;
                    default: res = s_full;
                endcase
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out    <= '0;
                    flag_n <= 1'b0;
                    flag_z <= 1'b0;
                    flag_c <= 1'b0;
                    flag_v <= 1'b0;
                end else if (adv[g] && pv[g]) begin
                    out    <= res;
                    flag_n <= n_nx;
                    flag_z <= z_nx;
                    flag_c <= c_nx;
                    flag_v <= v_nx;
                end
            end
        end
    end

endmodule
